uart_frame_rx: RTL and testbench
================================

// Module: uart_frame_rx
// PURPOSE
//  Frame parser downstream of the uart receive path. Consumes the byte stream
//  (data/valid/ready) and the line-error flag. Hunts for frame format
//  SOF, LEN, LEN payload bytes, CHK. Buffers each frame in full and releases it
//  only after the checksum verifies; bad frames are dropped and reported.
// PARAMETERS
//  SOF_BYTE  8'hA5   start-of-frame marker
//  MAX_LEN   16      max payload bytes (buffer depth); LEN legal range 1..MAX_LEN
//  TO_CYC    100000  inter-byte timeout in i_clk cycles while a frame is open
// PORTS
//  i_clk        in   1  clock
//  i_rst        in   1  asynchronous, active-low reset
//  i_data       in   8  received byte (from uart o_data)
//  i_valid      in   1  i_data valid
//  o_ready      out  1  byte accepted when i_valid & o_ready
//  i_rxerr      in   1  uart framing error (1-cycle pulse)
//  o_data       out  8  payload byte
//  o_valid      out  1  o_data valid
//  o_last       out  1  high with the final payload byte of a frame
//  i_ready      in   1  downstream ready
//  o_len        out  8  LEN of the frame being released; stable during DRAIN
//  o_drop       out  1  1-cycle pulse: frame discarded
//  o_drop_code  out  2  0=bad LEN, 1=bad CHK, 2=timeout, 3=line error; valid with o_drop
// BEHAVIOUR
//  Reset (i_rst=0, async): state=HUNT, pointers/counters/sum=0. o_ready=1.
//   o_valid, o_last, o_drop=0. o_len, o_drop_code=0. Buffer contents undefined.
//  o_ready=1 in HUNT/LEN/PAY/CHK, 0 in DRAIN (no input byte lost; uart holds it).
//  FSM, one accepted byte per transition:
//   HUNT: byte==SOF_BYTE -> LEN; any other byte is discarded silently.
//   LEN:  1<=byte<=MAX_LEN -> latch len, sum=byte, wptr=0 -> PAY.
//         Otherwise -> HUNT with o_drop, code 0. A SOF value here is treated as LEN.
//   PAY:  buf[wptr]=byte, sum+=byte (mod 256), wptr++.
//         After the len-th byte -> CHK.
//   CHK:  byte==sum -> DRAIN, rptr=0. Otherwise -> HUNT with o_drop, code 1.
//   DRAIN: o_valid=1, o_data=buf[rptr], o_last=(rptr==len-1).
//         On i_ready: rptr++. Handshake on the last byte -> HUNT.
//  Checksum: 8-bit modular sum of LEN and all payload bytes.
//  Latency: the CHK byte is accepted at edge N; o_valid=1 from edge N+1.
//   Output is registered state, not combinational from i_valid.
//  Handshake: o_data/o_last hold stable while o_valid & !i_ready.
//   Back-to-back output at 1 byte/cycle when i_ready=1.
//  Timeout: idle counter clears on every accepted byte. Counts only in LEN/PAY/CHK.
//   Reaching TO_CYC-1 with no byte -> HUNT, o_drop code 2.
//   Byte accepted in the same cycle as expiry: the byte wins, no drop.
//  i_rxerr in LEN/PAY/CHK -> HUNT, o_drop code 3. A byte in the same cycle is ignored.
//   i_rxerr in HUNT or DRAIN is ignored.
//  Drop pulse lasts exactly one cycle. Drop and transition occur on the same edge.
//   Any byte in the cycle after a drop is parsed from HUNT.
//  Frames are never emitted partially. A dropped frame leaves nothing in flight.
//  Reset mid-DRAIN aborts the output stream immediately (o_valid=0 async).
// TESTING
//  T1 good frame: A5 03 01 02 03 09, i_ready=1 -> 01,02,03 on consecutive cycles.
//     o_last on 03, o_len=3, no o_drop.
//  T2 bad chk: A5 02 10 20 00 -> no o_valid; o_drop 1 cycle, code 1; back in HUNT.
//  T3 bad len: A5 00, and A5 11 with MAX_LEN=16 -> o_drop code 0 each time.
//     A following good frame is received intact.
//  T4 backpressure: T1 frame with i_ready toggling 1010... -> o_data stable while stalled.
//     Sequence 01,02,03 in order; o_ready=0 until 03 handshakes.
//  T5 timeout/line err: A5 02 01 then idle TO_CYC cycles -> code 2.
//     A5 02 pulsed with i_rxerr -> code 3. Garbage 00 FF before SOF is ignored.
//  T6 async reset asserted mid-DRAIN -> o_valid=0, o_ready=1 immediately.
//     Next good frame parses correctly.

Source files
------------

// File: rtl/uart_frame_rx.sv
// ---------------------------------------------------------------------------
// uart_frame_rx
//   Frame parser sitting behind the uart receive path. It hunts for frames of
//   the form SOF, LEN, LEN payload bytes, CHK. Each frame is held in a local
//   buffer and released downstream only once its checksum has matched.
//   Frames that fail are discarded and reported with a one-cycle drop pulse.
//   The checksum is the 8-bit modular sum of LEN and all payload bytes.
//
// Ports
//   i_clk        clock
//   i_rst        asynchronous active-low reset
//   i_data[7:0]  received byte from the uart
//   i_valid      i_data valid
//   o_ready      byte accepted when i_valid & o_ready (low while draining)
//   i_rxerr      uart line/framing error pulse
//   o_data[7:0]  payload byte released downstream
//   o_valid      o_data valid
//   o_last       marks the final payload byte of a frame
//   i_ready      downstream ready
//   o_len[7:0]   LEN of the frame being released
//   o_drop       one-cycle pulse: frame discarded
//   o_drop_code  0=bad LEN, 1=bad CHK, 2=timeout, 3=line error
// ---------------------------------------------------------------------------
module uart_frame_rx #(
    parameter logic [7:0] SOF_BYTE = 8'hA5,
    parameter int         MAX_LEN  = 16,
    parameter int         TO_CYC   = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_rxerr,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_last,
    input  logic       i_ready,
    output logic [7:0] o_len,
    output logic       o_drop,
    output logic [1:0] o_drop_code
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CYC - 1);

    localparam logic [1:0] DROP_LEN     = 2'd0;
    localparam logic [1:0] DROP_CHK     = 2'd1;
    localparam logic [1:0] DROP_TIMEOUT = 2'd2;
    localparam logic [1:0] DROP_LINE    = 2'd3;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_LEN   = 3'd1,
        ST_PAY   = 3'd2,
        ST_CHK   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // 8-bit modular checksum accumulation
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t            state_r, state_s;
    logic [7:0]        len_r, len_s;
    logic [7:0]        sum_r, sum_s;
    logic [IDX_W-1:0]  wptr_r, wptr_s;
    logic [IDX_W-1:0]  rptr_r, rptr_s;
    logic [IDX_W-1:0]  rptr_inc_s;
    logic [TO_W-1:0]   idle_r, idle_s;
    logic [7:0]        data_r, data_s;
    logic              valid_r, valid_s;
    logic              last_r, last_s;
    logic              ready_r, ready_s;
    logic              drop_r, drop_s;
    logic [1:0]        code_r, code_s;
    logic              wr_en_s;
    logic              accept_s;
    logic              open_s;
    logic [7:0]        buf_r [MAX_LEN];

    assign accept_s   = i_valid & ready_r;
    // A frame is "open" once SOF has been seen and until CHK is judged.
    assign open_s     = (state_r == ST_LEN) || (state_r == ST_PAY) || (state_r == ST_CHK);
    assign rptr_inc_s = rptr_r + IDX_W'(1);

    // Next-state and next-output logic; line error beats a same-cycle byte,
    // and an accepted byte beats a same-cycle timeout expiry.
    always_comb begin
        state_s = state_r;
        len_s   = len_r;
        sum_s   = sum_r;
        wptr_s  = wptr_r;
        rptr_s  = rptr_r;
        idle_s  = idle_r;
        data_s  = data_r;
        valid_s = valid_r;
        last_s  = last_r;
        drop_s  = 1'b0;
        code_s  = code_r;
        wr_en_s = 1'b0;

        if (open_s && i_rxerr) begin
            state_s = ST_HUNT;
            idle_s  = '0;
            drop_s  = 1'b1;
            code_s  = DROP_LINE;
        end else if (open_s && !accept_s) begin
            if (idle_r == TO_LAST) begin
                state_s = ST_HUNT;
                idle_s  = '0;
                drop_s  = 1'b1;
                code_s  = DROP_TIMEOUT;
            end else begin
                idle_s = idle_r + TO_W'(1);
            end
        end else begin
            case (state_r)
                ST_HUNT: begin
                    idle_s = '0;
                    if (accept_s && (i_data == SOF_BYTE)) begin
                        state_s = ST_LEN;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_LEN: begin
                    idle_s = '0;
                    if ((i_data != 8'd0) && (i_data <= MAX_LEN_B)) begin
                        len_s   = i_data;
                        sum_s   = i_data;
                        wptr_s  = '0;
                        state_s = ST_PAY;
                    end else begin
                        state_s = ST_HUNT;
                        drop_s  = 1'b1;
                        code_s  = DROP_LEN;
                    end
                end
                ST_PAY: begin
                    idle_s  = '0;
                    wr_en_s = 1'b1;
                    sum_s   = sum8(sum_r, i_data);
                    if (8'(wptr_r) == (len_r - 8'd1)) begin
                        state_s = ST_CHK;
                    end else begin
                        wptr_s = wptr_r + IDX_W'(1);
                    end
                end
                ST_CHK: begin
                    idle_s = '0;
                    if (i_data == sum_r) begin
                        state_s = ST_DRAIN;
                        rptr_s  = '0;
                        valid_s = 1'b1;
                        data_s  = buf_r[IDX_W'(0)];
                        last_s  = (len_r == 8'd1);
                    end else begin
                        state_s = ST_HUNT;
                        drop_s  = 1'b1;
                        code_s  = DROP_CHK;
                    end
                end
                ST_DRAIN: begin
                    if (i_ready) begin
                        if (last_r) begin
                            state_s = ST_HUNT;
                            valid_s = 1'b0;
                            last_s  = 1'b0;
                        end else begin
                            rptr_s = rptr_inc_s;
                            data_s = buf_r[rptr_inc_s];
                            last_s = (8'(rptr_inc_s) == (len_r - 8'd1));
                        end
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_s = ST_HUNT;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                end
            endcase
        end

        ready_s = (state_s != ST_DRAIN);
    end

    // State, counters and registered outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= ST_HUNT;
            len_r   <= 8'd0;
            sum_r   <= 8'd0;
            wptr_r  <= '0;
            rptr_r  <= '0;
            idle_r  <= '0;
            data_r  <= 8'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            ready_r <= 1'b1;
            drop_r  <= 1'b0;
            code_r  <= 2'd0;
        end else begin
            state_r <= state_s;
            len_r   <= len_s;
            sum_r   <= sum_s;
            wptr_r  <= wptr_s;
            rptr_r  <= rptr_s;
            idle_r  <= idle_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            ready_r <= ready_s;
            drop_r  <= drop_s;
            code_r  <= code_s;
        end
    end

    // Payload buffer; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            buf_r[wptr_r] <= i_data;
        end
    end

    assign o_ready     = ready_r;
    assign o_data      = data_r;
    assign o_valid     = valid_r;
    assign o_last      = last_r;
    assign o_len       = len_r;
    assign o_drop      = drop_r;
    assign o_drop_code = code_r;

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;

    localparam int         TO   = 40;
    localparam int         MAXL = 16;
    localparam logic [7:0] SOF  = 8'hA5;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       i_rxerr;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic       i_ready;
    logic [7:0] o_len;
    logic       o_drop;
    logic [1:0] o_drop_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;   // 0: always 1, 1: toggle, 2: random, other: held 0

    typedef struct { logic [7:0] data; logic last; logic [7:0] len; int cyc; } out_t;
    typedef struct { logic [1:0] code; int cyc; } drop_t;
    out_t  out_q[$];
    drop_t drop_q[$];

    uart_frame_rx #(.SOF_BYTE(SOF), .MAX_LEN(MAXL), .TO_CYC(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .i_rxerr(i_rxerr), .o_data(o_data), .o_valid(o_valid),
        .o_last(o_last), .i_ready(i_ready), .o_len(o_len), .o_drop(o_drop),
        .o_drop_code(o_drop_code)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // record output handshakes and drop pulses with the edge they occur on
    always @(posedge i_clk) begin
        if (i_rst === 1'b1) begin
            if (o_valid === 1'b1 && i_ready === 1'b1) out_q.push_back('{o_data, o_last, o_len, cyc});
            if (o_drop === 1'b1) drop_q.push_back('{o_drop_code, cyc});
        end
    end

    always @(negedge i_clk) begin
        case (ready_mode)
            0: i_ready = 1'b1;
            1: i_ready = ~i_ready;
            2: i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b0;
        endcase
    end

    task automatic send_byte(input logic [7:0] b, output int acc);
        bit done = 0;
        acc = -1;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge i_clk);
            i_data = b; i_valid = 1'b1;
            if (o_ready === 1'b1) begin
                @(posedge i_clk);
                acc = cyc;
                done = 1;
            end
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL send_byte accept: byte %h not accepted, o_ready=%b required 1", b, o_ready); end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            i_valid = 1'b0; i_rxerr = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset o_ready: got %b want 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset o_valid: got %b want 0", o_valid); end
        checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset o_last: got %b want 0", o_last); end
        checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL reset o_drop: got %b want 0", o_drop); end
        checks++; if (o_len !== 8'd0) begin errors++; $display("FAIL reset o_len: got %h want 00", o_len); end
        checks++; if (o_drop_code !== 2'd0) begin errors++; $display("FAIL reset o_drop_code: got %0d want 0", o_drop_code); end
    endtask

    task automatic test_good();
        logic [7:0] f[6] = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        int acc = 0;
        ready_mode = 0; out_q.delete(); drop_q.delete();
        foreach (f[i]) send_byte(f[i], acc);
        idle(8);
        checks++; if (out_q.size() !== 3) begin errors++; $display("FAIL good count: got %0d want 3", out_q.size()); end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            checks++; if (out_q[i].data !== 8'(i + 1)) begin errors++; $display("FAIL good data[%0d]: got %h want %h", i, out_q[i].data, i + 1); end
            checks++; if (out_q[i].last !== 1'(i == 2)) begin errors++; $display("FAIL good last[%0d]: got %b", i, out_q[i].last); end
            checks++; if (out_q[i].len !== 8'd3) begin errors++; $display("FAIL good len[%0d]: got %h want 03", i, out_q[i].len); end
            checks++; if (out_q[i].cyc !== acc + 1 + i) begin errors++; $display("FAIL good timing[%0d]: edge %0d want %0d", i, out_q[i].cyc, acc + 1 + i); end
        end
        checks++; if (drop_q.size() !== 0) begin errors++; $display("FAIL good drops: got %0d want 0", drop_q.size()); end
    endtask

    task automatic test_bad_chk();
        logic [7:0] f[5] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        logic [7:0] g[4] = '{8'hA5, 8'h01, 8'h07, 8'h08};
        int acc = 0; int acc_chk = 0;
        ready_mode = 0; out_q.delete(); drop_q.delete();
        foreach (f[i]) send_byte(f[i], acc_chk);
        foreach (g[i]) send_byte(g[i], acc);   // immediately after the drop
        idle(8);
        checks++; if (drop_q.size() !== 1) begin errors++; $display("FAIL badchk drop count: got %0d want 1", drop_q.size()); end
        if (drop_q.size() > 0) begin
            checks++; if (drop_q[0].code !== 2'd1) begin errors++; $display("FAIL badchk code: got %0d want 1", drop_q[0].code); end
            checks++; if (drop_q[0].cyc !== acc_chk + 1) begin errors++; $display("FAIL badchk timing: edge %0d want %0d", drop_q[0].cyc, acc_chk + 1); end
        end
        checks++; if (out_q.size() !== 1) begin errors++; $display("FAIL badchk out count: got %0d want 1", out_q.size()); end
        if (out_q.size() > 0) begin
            checks++; if (out_q[0].data !== 8'h07 || out_q[0].last !== 1'b1) begin errors++; $display("FAIL badchk next frame: got %h/%b want 07/1", out_q[0].data, out_q[0].last); end
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] f[11] = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'h02, 8'hAA, 8'h55, 8'h01};
        int acc = 0;
        ready_mode = 0; out_q.delete(); drop_q.delete();
        foreach (f[i]) send_byte(f[i], acc);
        idle(8);
        checks++; if (drop_q.size() !== 3) begin errors++; $display("FAIL badlen drop count: got %0d want 3", drop_q.size()); end
        foreach (drop_q[i]) begin
            checks++; if (drop_q[i].code !== 2'd0) begin errors++; $display("FAIL badlen code[%0d]: got %0d want 0", i, drop_q[i].code); end
        end
        checks++; if (out_q.size() !== 2) begin errors++; $display("FAIL badlen out count: got %0d want 2", out_q.size()); end
        if (out_q.size() == 2) begin
            checks++; if (out_q[0].data !== 8'hAA || out_q[1].data !== 8'h55 || out_q[1].last !== 1'b1) begin
                errors++; $display("FAIL badlen next frame: got %h %h last %b want AA 55 last 1", out_q[0].data, out_q[1].data, out_q[1].last); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] f[6] = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        int acc = 0;
        logic pv = 1'b0; logic pr = 1'b1; logic [7:0] pd = 8'h00; logic pl = 1'b0;
        ready_mode = 1; out_q.delete(); drop_q.delete();
        foreach (f[i]) send_byte(f[i], acc);
        for (int k = 0; k < 30; k++) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            #1;
            if (o_valid === 1'b1) begin
                checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp o_ready in drain: got %b want 0", o_ready); end
            end
            if (pv && !pr) begin
                checks++; if (o_valid !== 1'b1 || o_data !== pd || o_last !== pl) begin
                    errors++; $display("FAIL bp stall hold: got %b/%h/%b want 1/%h/%b", o_valid, o_data, o_last, pd, pl); end
            end
            pv = o_valid; pr = i_ready; pd = o_data; pl = o_last;
        end
        ready_mode = 0;
        checks++; if (out_q.size() !== 3) begin errors++; $display("FAIL bp count: got %0d want 3", out_q.size()); end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            checks++; if (out_q[i].data !== 8'(i + 1)) begin errors++; $display("FAIL bp order[%0d]: got %h want %h", i, out_q[i].data, i + 1); end
        end
    endtask

    task automatic test_timeout_lineerr();
        logic [7:0] f[5] = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h01};
        logic [7:0] g[4] = '{8'hA5, 8'h01, 8'h44, 8'h45};
        int acc = 0;
        ready_mode = 0; out_q.delete(); drop_q.delete();
        foreach (f[i]) send_byte(f[i], acc);
        idle(TO + 10);
        checks++; if (drop_q.size() !== 1) begin errors++; $display("FAIL timeout drop count: got %0d want 1", drop_q.size()); end
        if (drop_q.size() > 0) begin
            checks++; if (drop_q[0].code !== 2'd2) begin errors++; $display("FAIL timeout code: got %0d want 2", drop_q[0].code); end
            checks++; if (drop_q[0].cyc < acc + TO - 1 || drop_q[0].cyc > acc + TO + 1) begin
                errors++; $display("FAIL timeout timing: edge %0d want about %0d", drop_q[0].cyc, acc + TO); end
        end
        checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL timeout output: got %0d bytes want 0", out_q.size()); end

        // slow but in-time bytes keep the frame alive
        out_q.delete(); drop_q.delete();
        send_byte(8'hA5, acc); send_byte(8'h02, acc);
        idle(TO - 4); send_byte(8'h11, acc);
        idle(TO - 4); send_byte(8'h22, acc);
        send_byte(8'h35, acc);
        idle(6);
        checks++; if (drop_q.size() !== 0) begin errors++; $display("FAIL slow frame drops: got %0d want 0", drop_q.size()); end
        checks++; if (out_q.size() !== 2) begin errors++; $display("FAIL slow frame count: got %0d want 2", out_q.size()); end
        else begin
            checks++; if (out_q[0].data !== 8'h11 || out_q[1].data !== 8'h22) begin errors++; $display("FAIL slow frame data: got %h %h want 11 22", out_q[0].data, out_q[1].data); end
        end

        // line error in HUNT is ignored; in an open frame it drops and eats the byte
        out_q.delete(); drop_q.delete();
        @(negedge i_clk); i_valid = 1'b0; i_rxerr = 1'b1;
        @(negedge i_clk); i_rxerr = 1'b0;
        send_byte(8'hA5, acc); send_byte(8'h02, acc);
        @(negedge i_clk); i_data = 8'h33; i_valid = 1'b1; i_rxerr = 1'b1;
        idle(3);
        foreach (g[i]) send_byte(g[i], acc);
        idle(6);
        checks++; if (drop_q.size() !== 1) begin errors++; $display("FAIL lineerr drop count: got %0d want 1", drop_q.size()); end
        else begin
            checks++; if (drop_q[0].code !== 2'd3) begin errors++; $display("FAIL lineerr code: got %0d want 3", drop_q[0].code); end
        end
        checks++; if (out_q.size() !== 1) begin errors++; $display("FAIL lineerr out count: got %0d want 1", out_q.size()); end
        else begin
            checks++; if (out_q[0].data !== 8'h44 || out_q[0].last !== 1'b1) begin errors++; $display("FAIL lineerr next frame: got %h/%b want 44/1", out_q[0].data, out_q[0].last); end
        end
    endtask

    task automatic test_reset_drain();
        logic [7:0] f[5] = '{8'hA5, 8'h02, 8'h0C, 8'h0D, 8'h1B};
        logic [7:0] g[4] = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        int acc = 0;
        ready_mode = 3; out_q.delete(); drop_q.delete();
        foreach (f[i]) send_byte(f[i], acc);
        idle(3);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rstdrain pre o_valid: got %b want 1", o_valid); end
        @(negedge i_clk); #2 i_rst = 1'b0; #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstdrain o_valid: got %b want 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rstdrain o_ready: got %b want 1", o_ready); end
        @(negedge i_clk); i_rst = 1'b1; ready_mode = 0;
        out_q.delete(); drop_q.delete();
        foreach (g[i]) send_byte(g[i], acc);
        idle(6);
        checks++; if (out_q.size() !== 1) begin errors++; $display("FAIL rstdrain after count: got %0d want 1", out_q.size()); end
        else begin
            checks++; if (out_q[0].data !== 8'h5A || out_q[0].last !== 1'b1 || out_q[0].len !== 8'h01) begin
                errors++; $display("FAIL rstdrain after frame: got %h/%b/%h want 5A/1/01", out_q[0].data, out_q[0].last, out_q[0].len); end
        end
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        logic [7:0] exp_d[$]; logic exp_l[$]; int exp_len[$]; logic [1:0] exp_drop[$];
        logic [7:0] p[$];
        int acc = 0; int i = 0; int len = 0; int sum = 0; int kind = 0;
        logic [7:0] b;
        // build a stream of good, bad-checksum and bad-length frames with garbage between
        for (int f = 0; f < 25; f++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                b = 8'($urandom_range(0, 255));
                if (b == SOF) b = 8'h00;
                s.push_back(b);
            end
            kind = $urandom_range(0, 9);
            s.push_back(SOF);
            if (kind >= 8) begin
                s.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
            end else begin
                len = $urandom_range(1, MAXL);
                s.push_back(8'(len));
                sum = len;
                for (int j = 0; j < len; j++) begin
                    b = 8'($urandom_range(0, 255));
                    s.push_back(b);
                    sum = (sum + int'(b)) % 256;
                end
                if (kind >= 6) sum = (sum + $urandom_range(1, 255)) % 256;
                s.push_back(8'(sum));
            end
        end
        // reference parse of the stream
        i = 0;
        while (i < s.size()) begin
            if (s[i] != SOF) begin
                i++;
            end else begin
                len = int'(s[i + 1]);
                i += 2;
                if (len < 1 || len > MAXL) begin
                    exp_drop.push_back(2'd0);
                end else begin
                    sum = len; p.delete();
                    for (int j = 0; j < len; j++) begin
                        p.push_back(s[i]);
                        sum = (sum + int'(s[i])) % 256;
                        i++;
                    end
                    if (int'(s[i]) == sum) begin
                        foreach (p[j]) begin exp_d.push_back(p[j]); exp_l.push_back(1'(j == len - 1)); exp_len.push_back(len); end
                    end else begin
                        exp_drop.push_back(2'd1);
                    end
                    i++;
                end
            end
        end
        ready_mode = 2; out_q.delete(); drop_q.delete();
        foreach (s[k]) send_byte(s[k], acc);
        idle(1);
        for (int k = 0; k < 3000 && out_q.size() < exp_d.size(); k++) @(negedge i_clk);
        idle(5);
        ready_mode = 0;
        checks++; if (out_q.size() !== exp_d.size()) begin errors++; $display("FAIL random out count: got %0d want %0d", out_q.size(), exp_d.size()); end
        for (int k = 0; k < out_q.size() && k < exp_d.size(); k++) begin
            checks++;
            if (out_q[k].data !== exp_d[k] || out_q[k].last !== exp_l[k] || int'(out_q[k].len) !== exp_len[k]) begin
                errors++; $display("FAIL random byte[%0d]: got %h/%b/%0d want %h/%b/%0d", k, out_q[k].data, out_q[k].last, out_q[k].len, exp_d[k], exp_l[k], exp_len[k]);
            end
        end
        checks++; if (drop_q.size() !== exp_drop.size()) begin errors++; $display("FAIL random drop count: got %0d want %0d", drop_q.size(), exp_drop.size()); end
        for (int k = 0; k < drop_q.size() && k < exp_drop.size(); k++) begin
            checks++; if (drop_q[k].code !== exp_drop[k]) begin errors++; $display("FAIL random drop[%0d]: got %0d want %0d", k, drop_q[k].code, exp_drop[k]); end
        end
    endtask

    initial begin
        i_rst = 1'b0; i_data = 8'h00; i_valid = 1'b0; i_rxerr = 1'b0; i_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        test_reset();
        i_rst = 1'b1;
        idle(2);
        test_good();
        test_bad_chk();
        test_bad_len();
        test_backpressure();
        test_timeout_lineerr();
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
